// File: rtl/mem_dump_pkg.sv
// ============================================================================
// Module   : mem_dump_pkg
// Brief    : Shared types and default constants for the mem_dump_reader slice.
//            Optional feature macro: MEM_DUMP_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package mem_dump_pkg;

  // Sequencer states; explicit 2-bit encoding.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Default geometry of the `memory` block RAM.
  localparam int DEF_ADDR_W    = 13;
  localparam int DEF_WID_MEM   = 9;
  localparam int DEF_DEPTH_MEM = 8192;
  localparam int DEF_RD_LAT    = 1;

  // Extra bits carried by the running checksum above the word width.
  localparam int CHKSUM_EXT    = 16;

  // Next sequential address, wrapping from depth-1 back to 0.
  function automatic int unsigned wrap_inc(input int unsigned addr,
                                           input int unsigned depth);
    return (addr == depth - 1) ? 0 : addr + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_dump_if.sv
// ============================================================================
// Module   : mem_dump_if
// Brief    : Valid/ready stream carrying dumped RAM words plus a last marker.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface mem_dump_if #(
  parameter int WID_MEM = 9
) ();

  logic [WID_MEM-1:0] m_data;
  logic               m_valid;
  logic               m_ready;
  logic               m_last;

  modport master (output m_data, output m_valid, output m_last, input  m_ready);
  modport slave  (input  m_data, input  m_valid, input  m_last, output m_ready);

endinterface

`default_nettype wire

// File: rtl/dump_skid_fifo.sv
// ============================================================================
// Module   : dump_skid_fifo
// Brief    : 2-entry FIFO between the RAM capture point and the stream port.
//            Output word and last flag come straight from storage registers,
//            so they cannot change while the head entry is waiting for pop.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module dump_skid_fifo #(
  parameter int WID_MEM = 9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [WID_MEM-1:0] din,
  input  logic               din_last,
  input  logic               pop,
  output logic [WID_MEM-1:0] dout,
  output logic               dout_last,
  output logic [1:0]         occupancy,
  output logic               full,
  output logic               empty
);

  logic [1:0][WID_MEM-1:0] r_data;
  logic [1:0]              r_last;
  logic                    r_wr;
  logic                    r_rd;
  logic [1:0]              r_occ;

  // Storage, pointers and occupancy. On a full FIFO with push and pop the
  // write slot equals the head slot, which is being consumed this cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data <= '0;
      r_last <= '0;
      r_wr   <= 1'b0;
      r_rd   <= 1'b0;
      r_occ  <= 2'd0;
    end else begin
      if (push) begin
        r_data[r_wr] <= din;
        r_last[r_wr] <= din_last;
        r_wr         <= ~r_wr;
      end
      if (pop) begin
        r_rd <= ~r_rd;
      end
      r_occ <= r_occ + {1'b0, push} - {1'b0, pop};
    end
  end

  assign dout      = r_data[r_rd];
  assign dout_last = r_last[r_rd];
  assign occupancy = r_occ;
  assign full      = (r_occ == 2'd2);
  assign empty     = (r_occ == 2'd0);

endmodule

`default_nettype wire

// File: rtl/mem_dump_reader.sv
// ============================================================================
// Module   : mem_dump_reader
// Brief    : Streams a contiguous, wrapping address window of the `memory`
//            block RAM out over a valid/ready port with backpressure.
//            Optional macro MEM_DUMP_CHECKSUM_EN adds a running checksum port.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mem_dump_reader
  import mem_dump_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int WID_MEM   = DEF_WID_MEM,
  parameter int DEPTH_MEM = DEF_DEPTH_MEM,
  parameter int RD_LAT    = DEF_RD_LAT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic [ADDR_W:0]    count,
  output logic [ADDR_W-1:0]  raddr,
  input  logic [WID_MEM-1:0] rdata,
  mem_dump_if.master         m,
  output logic               busy,
  output logic               done
`ifdef MEM_DUMP_CHECKSUM_EN
  ,
  output logic [WID_MEM+CHKSUM_EXT-1:0] checksum
`endif
);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_ptr;        // next address to issue
  logic [ADDR_W-1:0]   r_last_addr;  // most recently issued address
  logic [ADDR_W:0]     r_remaining;  // addresses still to issue
  logic [RD_LAT-1:0]   r_pend;       // read-in-flight pipeline
  logic [RD_LAT-1:0]   r_pend_last;  // last-beat tag riding with each read
  logic                r_busy;
  logic                r_done;

  logic                w_issue;
  logic                w_issue_last;
  logic                w_push;
  logic                w_push_last;
  logic                w_pop;
  logic [WID_MEM-1:0]  w_data;
  logic                w_data_last;
  logic [1:0]          w_occ;
  logic                w_full;
  logic                w_empty;
  logic [7:0]          w_inflight;
  logic [7:0]          w_ahead;

  // Reads issued but not yet captured into the FIFO.
  always_comb begin
    w_inflight = 8'd0;
    for (int i = 0; i < RD_LAT; i++) begin
      w_inflight = w_inflight + 8'(r_pend[i]);
    end
  end

  // Words that will still be held (stored or in flight) after this cycle,
  // before counting a new issue. Keeping this below 2 bounds the FIFO.
  assign w_ahead      = 8'(w_occ) + w_inflight - 8'(w_pop);
  assign w_issue      = (r_state == RUN) && (r_remaining != '0) &&
                        (w_ahead < 8'd2) && (!w_full || w_pop);
  assign w_issue_last = (r_remaining == (ADDR_W+1)'(1));
  assign w_pop        = !w_empty && m.m_ready;
  assign w_push       = r_pend[RD_LAT-1];
  assign w_push_last  = r_pend_last[RD_LAT-1];

  // Issued address appears on raddr in its issue cycle, otherwise it holds.
  assign raddr = w_issue ? r_ptr : r_last_addr;

  // Read-latency pipeline aligning the capture with the RAM output.
  generate
    if (RD_LAT == 1) begin : g_lat_one
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_pend      <= '0;
          r_pend_last <= '0;
        end else begin
          r_pend      <= w_issue;
          r_pend_last <= w_issue && w_issue_last;
        end
      end
    end else begin : g_lat_multi
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_pend      <= '0;
          r_pend_last <= '0;
        end else begin
          r_pend      <= {r_pend[RD_LAT-2:0], w_issue};
          r_pend_last <= {r_pend_last[RD_LAT-2:0], w_issue && w_issue_last};
        end
      end
    end
  endgenerate

  // Sequencer: state, address walk, remaining count and status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_last_addr <= '0;
      r_remaining <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= (r_state == DONE);
      if (w_issue) begin
        r_last_addr <= r_ptr;
        r_ptr       <= ADDR_W'(wrap_inc(32'(r_ptr), 32'(DEPTH_MEM)));
        r_remaining <= r_remaining - (ADDR_W+1)'(1);
      end
      case (r_state)
        IDLE: begin
          if (start) begin
            if (count != '0) begin
              r_ptr       <= base_addr;
              r_remaining <= count;
              r_busy      <= 1'b1;
              r_state     <= RUN;
            end else begin
              r_state     <= DONE;
            end
          end
        end
        RUN: begin
          if (w_issue && w_issue_last) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          // Leave once the final beat is accepted in this very cycle.
          if (w_ahead == 8'd0) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  dump_skid_fifo #(
    .WID_MEM   (WID_MEM)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (w_push),
    .din       (rdata),
    .din_last  (w_push_last),
    .pop       (w_pop),
    .dout      (w_data),
    .dout_last (w_data_last),
    .occupancy (w_occ),
    .full      (w_full),
    .empty     (w_empty)
  );

  assign m.m_data  = w_data;
  assign m.m_valid = !w_empty;
  assign m.m_last  = !w_empty && w_data_last;
  assign busy      = r_busy;
  assign done      = r_done;

`ifdef MEM_DUMP_CHECKSUM_EN
  logic [WID_MEM+CHKSUM_EXT-1:0] r_chk;

  // Running sum of accepted beats, cleared when a dump request is taken.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_chk <= '0;
    end else if ((r_state == IDLE) && start) begin
      r_chk <= '0;
    end else if (w_pop) begin
      r_chk <= r_chk + (WID_MEM+CHKSUM_EXT)'(w_data);
    end
  end

  assign checksum = r_chk;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_dump_reader.sv
// ============================================================================
// Module   : tb_mem_dump_reader
// Brief    : Directed self-checking bench for mem_dump_reader with a
//            behavioural 1-cycle-latency RAM (word = low 9 address bits).
//            Checksum checks are built when MEM_DUMP_CHECKSUM_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mem_dump_reader;

  localparam int DEPTH = 8192;

  logic        clk       = 1'b0;
  logic        reset     = 1'b0;
  logic        start     = 1'b0;
  logic [12:0] base_addr = '0;
  logic [13:0] count     = '0;
  logic [12:0] raddr;
  logic [8:0]  rdata;
  logic        busy;
  logic        done;
`ifdef MEM_DUMP_CHECKSUM_EN
  logic [24:0] checksum;
`endif

  int checks = 0;
  int errors = 0;

  logic [8:0] ram [0:DEPTH-1];

  mem_dump_if #(.WID_MEM(9)) sif ();

  always #5 clk = ~clk;

  // Registered-output RAM, one cycle of read latency.
  always @(posedge clk) rdata <= ram[raddr];

  mem_dump_reader #(
    .ADDR_W    (13),
    .WID_MEM   (9),
    .DEPTH_MEM (DEPTH),
    .RD_LAT    (1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .count     (count),
    .raddr     (raddr),
    .rdata     (rdata),
    .m         (sif.master),
    .busy      (busy),
    .done      (done)
`ifdef MEM_DUMP_CHECKSUM_EN
    ,
    .checksum  (checksum)
`endif
  );

  // Stream monitor: logs accepted beats, watches hold-stability while
  // stalled, and tracks how far issued reads run ahead of accepted beats.
  logic [8:0]  beat_d [$];
  logic        beat_l [$];
  int          stab_viol = 0;
  int          issued    = 0;
  int          accepted  = 0;
  int          ahead_max = 0;
  logic        prev_v    = 1'b0;
  logic        prev_r    = 1'b0;
  logic [8:0]  prev_d    = '0;
  logic [12:0] prev_a    = '0;

  always @(negedge clk) begin
    if (!reset) begin
      prev_v   = 1'b0;
      issued   = 0;
      accepted = 0;
      prev_a   = raddr;
    end else begin
      if (prev_v && !prev_r && !(sif.m_valid === 1'b1 && sif.m_data === prev_d))
        stab_viol++;
      if (busy === 1'b1 && raddr !== prev_a) issued++;
      if (sif.m_valid === 1'b1 && sif.m_ready === 1'b1) begin
        beat_d.push_back(sif.m_data);
        beat_l.push_back(sif.m_last);
        accepted++;
      end
      if (issued - accepted > ahead_max) ahead_max = issued - accepted;
      prev_v = sif.m_valid;
      prev_r = sif.m_ready;
      prev_d = sif.m_data;
      prev_a = raddr;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int b, input int n);
    base_addr = 13'(b);
    count     = 14'(n);
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_done(input int budget, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (done === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic check_dump(input string tag, input int base, input int n);
    chk({tag, "_nbeats"}, beat_d.size(), n);
    for (int i = 0; i < n && i < beat_d.size(); i++) begin
      chk($sformatf("%s_data%0d", tag, i), beat_d[i], ((base + i) % DEPTH) & 'h1FF);
      chk($sformatf("%s_last%0d", tag, i), beat_l[i], (i == n - 1));
    end
  endtask

  task automatic clear_log();
    beat_d.delete();
    beat_l.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    int   n_at_reset;

    for (int a = 0; a < DEPTH; a++) ram[a] = 9'(a);
    sif.m_ready = 1'b0;

    // Reset state.
    tick();
    tick();
    chk("rst_raddr", raddr, 0);
    chk("rst_valid", sif.m_valid, 0);
    chk("rst_last",  sif.m_last, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_done",  done, 0);
    reset = 1'b1;
    tick();

    // Basic 4-word dump at full rate; first beat two edges after start.
    sif.m_ready = 1'b1;
    do_start('h010, 4);
    chk("t1_busy",   busy, 1);
    chk("t1_valid0", sif.m_valid, 0);
    tick();
    chk("t1_valid1", sif.m_valid, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("t1_v%0d", i), sif.m_valid, 1);
      chk($sformatf("t1_d%0d", i), sif.m_data, 'h010 + i);
      chk($sformatf("t1_l%0d", i), sif.m_last, (i == 3));
    end
    tick();
    chk("t1_done_early", done, 0);
    chk("t1_valid_off",  sif.m_valid, 0);
    tick();
    chk("t1_done",       done, 1);
    chk("t1_busy_off",   busy, 0);
`ifdef MEM_DUMP_CHECKSUM_EN
    chk("t1_checksum",   checksum, 'h046);
`endif
    tick();
    chk("t1_done_pulse", done, 0);
    check_dump("t1", 'h010, 4);

    // Wrapping window: raddr walks 1FFE, 1FFF, 0000, 0001 then holds.
    clear_log();
    do_start('h1FFE, 4);
    chk("t2_ra0", raddr, 'h1FFE);
`ifdef MEM_DUMP_CHECKSUM_EN
    chk("t2_chk_clear", checksum, 0);
`endif
    tick();
    chk("t2_ra1", raddr, 'h1FFF);
    tick();
    chk("t2_ra2", raddr, 'h0000);
    tick();
    chk("t2_ra3", raddr, 'h0001);
    tick();
    chk("t2_ra_hold", raddr, 'h0001);
    wait_done(20, seen);
    chk("t2_done_seen", seen, 1);
    check_dump("t2", 'h1FFE, 4);

    // Backpressure: ready toggles each cycle with a 5-cycle stall.
    clear_log();
    sif.m_ready = 1'b0;
    do_start('h020, 16);
    seen = 1'b0;
    for (int cyc = 0; cyc < 200 && !seen; cyc++) begin
      sif.m_ready = (cyc >= 10 && cyc < 15) ? 1'b0 : (cyc % 2 == 0);
      tick();
      if (done === 1'b1) seen = 1'b1;
    end
    sif.m_ready = 1'b1;
    chk("t3_done_seen", seen, 1);
    check_dump("t3", 'h020, 16);
    chk("t3_stable",   stab_viol, 0);
    chk("t3_ahead_le2", (ahead_max <= 2), 1);

    // count=0: no beats, done in the cycle after the DONE state.
    clear_log();
    tick();
    do_start('h055, 0);
    chk("t4_busy",  busy, 0);
    chk("t4_done0", done, 0);
    tick();
    chk("t4_done1", done, 1);
    chk("t4_valid", sif.m_valid, 0);
    tick();
    chk("t4_done2", done, 0);
    chk("t4_nbeats", beat_d.size(), 0);

    // Second start while busy is ignored.
    do_start('h040, 8);
    tick();
    tick();
    base_addr = 13'h100;
    count     = 14'd3;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    wait_done(40, seen);
    chk("t4b_done_seen", seen, 1);
    for (int i = 0; i < 5; i++) tick();
    chk("t4b_idle_busy", busy, 0);
    check_dump("t4b", 'h040, 8);

    // Asynchronous reset after the third beat of a 10-word dump.
    clear_log();
    do_start('h080, 10);
    seen = 1'b0;
    for (int cyc = 0; cyc < 40 && !seen; cyc++) begin
      tick();
      if (beat_d.size() >= 3) seen = 1'b1;
    end
    chk("t5_three_beats", seen, 1);
    reset = 1'b0;
    #1;
    chk("t5_raddr", raddr, 0);
    chk("t5_valid", sif.m_valid, 0);
    chk("t5_last",  sif.m_last, 0);
    chk("t5_busy",  busy, 0);
    chk("t5_done",  done, 0);
    n_at_reset = beat_d.size();
    chk("t5_n_at_reset", n_at_reset, 3);
    tick();
    tick();
    reset = 1'b1;
    tick();
    tick();
    chk("t5_no_more_beats", beat_d.size(), 3);
    chk("t5_idle_valid", sif.m_valid, 0);
    clear_log();
    do_start('h000, 2);
    wait_done(20, seen);
    chk("t5b_done_seen", seen, 1);
    check_dump("t5b", 'h000, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
